// File: rtl/iter_sched_pkg.sv
// Shared types and elaboration-time helpers for the iterative-IK period sequencer.
// Provides the FSM state encoding, the minimum count-width helper and the parameter check.
package iter_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    function automatic int min_cnt_w(input int period);
        return (period <= 2) ? 1 : $clog2(period);
    endfunction

endpackage

`define ITER_SCHED_PARAM_CHECK(period, cnt_w, n_ch) \
    if (!((period) >= 2 && (cnt_w) >= iter_sched_pkg::min_cnt_w(period) && (n_ch) >= 1)) begin : g_param_illegal \
        $error("iter_sched: illegal parameter set"); \
    end

// File: rtl/iter_sched_phase_strobe.sv
// One programmable phase strobe: latches its offset on start and emits a registered,
// en-gated pulse in the en-cycle after the running count matches that offset.
module phase_strobe #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic             active,
    input  logic [CNT_W-1:0] offset,
    input  logic [CNT_W-1:0] count,
    output logic             pulse
);

    logic [CNT_W-1:0] offset_q;

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            offset_q <= '0;
            pulse    <= 1'b0;
        end else begin
            if (load)
                offset_q <= offset;
            // Comparison is gated by active so the idle count of 0 never fires offset 0.
            if (en)
                pulse <= active && (count == offset_q);
        end
    end

endmodule

// File: rtl/iter_sched.sv
// Period sequencer: start/stop FSM, modulo-PERIOD phase counter, completed-period counter
// and N_CH phase-strobe channels that drive the datapath restart pulses.
module iter_sched
    import iter_sched_pkg::*;
#(
    parameter int PERIOD = 91,
    parameter int CNT_W  = 8,
    parameter int N_CH   = 4,
    parameter int ITER_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       mode,
    input  logic [N_CH-1:0][CNT_W-1:0] ch_offset,
    output logic [CNT_W-1:0]           count,
    output logic                       busy,
    output logic [N_CH-1:0]            ch_pulse,
    output logic                       period_done,
    output logic [ITER_W-1:0]          iter_cnt
);

    `ITER_SCHED_PARAM_CHECK(PERIOD, CNT_W, N_CH)

    state_t              state, state_next;
    logic                mode_q;
    logic                accept, active, wrap;
    logic [CNT_W-1:0]    count_next;
    logic [ITER_W-1:0]   iter_next;
    logic                done_next, busy_next;

    assign active = (state != IDLE);
    assign accept = (state == IDLE) && start;
    assign wrap   = (count == CNT_W'(PERIOD - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // NOTE: each combinational block assigns defaults first so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:
                if (start)
                    state_next = RUN;
            RUN:
                if (en) begin
                    if (wrap)
                        state_next = (mode_q && !stop) ? RUN : IDLE;
                    else if (stop)
                        state_next = DRAIN;
                end
            DRAIN:
                if (en && wrap)
                    state_next = IDLE;
            default:
                state_next = IDLE;
        endcase
    end

    always_comb begin
        count_next = count;
        iter_next  = iter_cnt;
        done_next  = period_done;
        busy_next  = (state_next != IDLE);
        if (accept) begin
            count_next = '0;
            iter_next  = '0;
        end else if (active && en) begin
            count_next = wrap ? '0 : count + CNT_W'(1);
            if (wrap)
                iter_next = iter_cnt + ITER_W'(1);
        end
        // period_done only moves on en-cycles so it stretches across stalls.
        if (en)
            done_next = active && wrap;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count       <= '0;
            iter_cnt    <= '0;
            period_done <= 1'b0;
            busy        <= 1'b0;
            mode_q      <= 1'b0;
        end else begin
            count       <= count_next;
            iter_cnt    <= iter_next;
            period_done <= done_next;
            busy        <= busy_next;
            if (accept)
                mode_q <= mode;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        phase_strobe #(
            .CNT_W(CNT_W)
        ) u_strobe (
            .clk   (clk),
            .rst   (rst),
            .load  (accept),
            .en    (en),
            .active(active),
            .offset(ch_offset[i]),
            .count (count),
            .pulse (ch_pulse[i])
        );
    end

endmodule

// File: doc/iter_sched.md
Name: iter_sched

Overview:
Parametrised period sequencer for the iterative IK datapath. It generalises the fixed modulo-91 count and hard-wired "delayed reset at count 4" into N_CH independently programmable phase strobes, and adds a start/stop FSM with single-shot and free-run modes plus a completed-period counter. It sits beside full_mat and drives its count input, the per-unit restart pulses (mat_mult, array_mult, t_block) and the iteration bookkeeping.

Parameters:
PERIOD, 91, cycles per iteration; count runs 0..PERIOD-1.
CNT_W, 8, count and offset width; must satisfy 2**CNT_W >= PERIOD.
N_CH, 4, number of phase-strobe channels.
ITER_W, 16, width of the completed-period counter.

Ports:
clk  in  1  clock.
rst  in  1  asynchronous active-high reset.
en  in  1  global advance enable; low = stall, all state holds.
start  in  1  run request; sampled only in IDLE.
stop  in  1  graceful-stop request; sampled in RUN.
mode  in  1  0 = single-shot, 1 = free-run; latched on start.
ch_offset  in  N_CH x CNT_W  per-channel strobe phase; latched on start.
count  out  CNT_W  current phase.
busy  out  1  high in RUN or DRAIN.
ch_pulse  out  N_CH  registered phase strobes.
period_done  out  1  one en-cycle pulse at each period end.
iter_cnt  out  ITER_W  periods completed since last start.

Behaviour:
- Reset (async, any state): state=IDLE; count=0, busy=0, ch_pulse=0, period_done=0, iter_cnt=0; latched mode/offsets cleared.
- States: IDLE, RUN, DRAIN (enum in package).
- IDLE: start=1 (en is ignored) -> RUN next cycle. On that edge: count=0, iter_cnt=0, mode and ch_offset latched, and busy=1 from the next cycle.
- RUN/DRAIN, en=1: count increments. At count==PERIOD-1 it wraps to 0, period_done=1 for the following cycle, and iter_cnt increments, wrapping modulo 2**ITER_W.
- RUN at wrap: if mode=0 -> IDLE. If mode=1 -> stay in RUN.
- RUN, stop=1 with en=1: if the same cycle is the wrap, go directly to IDLE; otherwise go to DRAIN. DRAIN finishes the current period, then goes to IDLE at the wrap. stop is ignored in IDLE and DRAIN.
- Returning to IDLE: count is forced to 0 and busy drops on the same edge as the final period_done.
- ch_pulse[i] is registered. It is high for exactly the one en-cycle that follows the en-cycle where count==latched offset[i]. This is the original "rst <= count==4" timing.
- Offsets >= PERIOD never fire.
- Several channels with equal offsets fire together.
- A channel whose offset is PERIOD-1 fires in the first cycle after the wrap, even when that wrap ends the run. That pulse is emitted while in IDLE, then clears on the next en-cycle.
- en=0: count, state, ch_pulse, period_done and iter_cnt all hold, so pulses stretch across stalls. This matches downstream units that gate their own rst sampling with en.
- start while busy: ignored, no restart.
- start and stop together in IDLE: start wins, stop is ignored.
- Outputs are fully registered. There is no combinational path from inputs to outputs.

Decomposition:
- Package iter_sched_pkg holds:
  - state_t enum {IDLE, RUN, DRAIN};
  - the localparam helper for the minimum CNT_W given PERIOD;
  - a parameter-legality assertion macro (PERIOD>=2, 2**CNT_W>=PERIOD, N_CH>=1).
- One sub-module, phase_strobe, instantiated N_CH times via generate. Each instance holds the offset latch, the comparator and the en-gated pulse register. The top holds the FSM, the counter and iter_cnt.

Test Plan:
- Single-shot, PERIOD=91, offset[0]=4: rst, then start pulse with mode=0, en=1 constant -> count 0..90 once; ch_pulse[0] high only when count==5; period_done once; iter_cnt=1; busy low after the wrap; count stays 0.
- Free-run, 3 periods, then stop at count 40: iter_cnt reaches 3; DRAIN is held until count==90; the fourth period_done is final; iter_cnt=4; IDLE.
- Stall: en low for 7 cycles while ch_pulse[1] is high (offset 10) -> pulse stays high for the stall and count stays 11; after en returns, exactly one more en-cycle high.
- Boundary offsets {0, 90, 91, 90}: ch0 fires at count 1; ch1 and ch3 fire together in the first cycle after the wrap, even in single-shot; ch2 never fires.
- Async rst asserted mid-RUN at count 57, between clock edges -> all outputs zero immediately without a clock edge; start afterwards restarts cleanly from count 0.
- start pulsed at count 30 during RUN and together with stop in IDLE -> the first is ignored (count continues 31); the second starts the run, and stop has no effect.
